cache_req_arbiter: RTL

CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

---
 rtl/cache_pkg.sv | 13 +
 rtl/cache_rr_grant.sv | 27 ++
 rtl/cache_req_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the two-requester cache lookup arbiter.
package cache_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESPOND  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/cache_rr_grant.sv
// Two-way round-robin grant: on contention the requester that did not win last time is chosen.
module cache_rr_grant
  import cache_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic               grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    if (valid == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (valid[1]) begin
      grant_idx = 1'b1;
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (|valid) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Arbitrates two lookup requesters onto one cache controller port, one lookup in flight at a time.
//
// state       | meaning
// ST_IDLE     | waiting for a request; grant and latch it in the same cycle
// ST_ISSUE    | presenting latched index/tag to the cache controller
// ST_WAIT_RSP | waiting for the hit/miss result
// ST_RESPOND  | holding the result for the granted requester
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 10,
  parameter int TAG_WIDTH   = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*INDEX_WIDTH-1:0] req_index,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_hit,
  output logic [2*NUM_REQ-1:0]           rsp_col,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [INDEX_WIDTH-1:0]         c_index,
  output logic [TAG_WIDTH-1:0]           c_tag,
  output logic                           c_it_valid,
  input  logic                           c_it_ready,
  input  logic                           c_hit_miss,
  input  logic [1:0]                     c_col,
  input  logic                           c_hm_valid,
  output logic                           c_hm_ready,
  output logic [CNT_WIDTH-1:0]           hit_cnt,
  output logic [CNT_WIDTH-1:0]           miss_cnt
);

  arb_state_t             state;
  logic                   last_grant;
  logic                   cur_grant;
  logic [NUM_REQ-1:0]     grant_onehot;
  logic                   grant_idx;
  logic [INDEX_WIDTH-1:0] sel_index;
  logic [TAG_WIDTH-1:0]   sel_tag;
  logic                   hm_fire;

  cache_rr_grant u_rr_grant (
    .valid        (req_valid),
    .last_grant   (last_grant),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign sel_index = grant_idx ? req_index[INDEX_WIDTH +: INDEX_WIDTH] : req_index[0 +: INDEX_WIDTH];
  assign sel_tag   = grant_idx ? req_tag[TAG_WIDTH +: TAG_WIDTH] : req_tag[0 +: TAG_WIDTH];

  // The grant is combinational so a request is accepted in the cycle it is seen in IDLE.
  assign req_ready = (state == ST_IDLE && !rst) ? grant_onehot : '0;

  assign hm_fire = c_hm_valid && c_hm_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      cur_grant  <= 1'b0;
      c_index    <= '0;
      c_tag      <= '0;
      c_it_valid <= 1'b0;
      c_hm_ready <= 1'b0;
      rsp_valid  <= '0;
      rsp_hit    <= '0;
      rsp_col    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            cur_grant  <= grant_idx;
            c_index    <= sel_index;
            c_tag      <= sel_tag;
            c_it_valid <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (c_it_ready) begin
            c_it_valid <= 1'b0;
            c_hm_ready <= 1'b1;
            state      <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (c_hm_valid) begin
            c_hm_ready <= 1'b0;
            if (cur_grant) begin
              rsp_valid <= 2'b10;
              rsp_hit   <= {c_hit_miss, 1'b0};
              rsp_col   <= {c_col, 2'b00};
            end else begin
              rsp_valid <= 2'b01;
              rsp_hit   <= {1'b0, c_hit_miss};
              rsp_col   <= {2'b00, c_col};
            end
            state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready[cur_grant]) begin
            rsp_valid  <= '0;
            rsp_hit    <= '0;
            rsp_col    <= '0;
            last_grant <= cur_grant;
            state      <= ST_IDLE;
          end
        end
        default: begin
          c_it_valid <= 1'b0;
          c_hm_ready <= 1'b0;
          rsp_valid  <= '0;
          rsp_hit    <= '0;
          rsp_col    <= '0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics saturate at all-ones so a long run never reads back as a small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (hm_fire) begin
      if (c_hit_miss) begin
        if (hit_cnt != {CNT_WIDTH{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != {CNT_WIDTH{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule
